dem_tree_recombiner: RTL

Check block for the three-layer DEM switching tree. Sums the eight leaf codes through a pipelined adder tree and compares the result against the tree's input code, delayed to line up with the leaves. Conservation holds when the sum of the leaves equals the code that entered the tree, and the block flags any cycle where it fails. It sits beside the switching-tree layers: it receives the same input code and the eight layer-3 outputs, and it drives status only, never the DAC elements.

---
 rtl/dem_tree_recombiner_if.sv | 47 ++++
 rtl/dem_tree_recombiner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dem_tree_recombiner_if.sv
// Bundle between the DEM switching tree and its recombiner check block:
// the tree input code, the eight layer-3 leaf codes, the clear strobe
// and the status returned by the checker.
interface dem_tree_recombiner_if #(
  parameter int unsigned INPUT_WIDTH = 4,
  parameter int unsigned ERR_CNT_W   = 16
);

  // Tree side
  logic                   valid_i;
  logic [INPUT_WIDTH-1:0] x_in_i;
  logic [INPUT_WIDTH-1:0] x_leaf1_i;
  logic [INPUT_WIDTH-1:0] x_leaf2_i;
  logic [INPUT_WIDTH-1:0] x_leaf3_i;
  logic [INPUT_WIDTH-1:0] x_leaf4_i;
  logic [INPUT_WIDTH-1:0] x_leaf5_i;
  logic [INPUT_WIDTH-1:0] x_leaf6_i;
  logic [INPUT_WIDTH-1:0] x_leaf7_i;
  logic [INPUT_WIDTH-1:0] x_leaf8_i;
  logic                   clear_i;

  // Status side
  logic                   valid_o;
  logic [INPUT_WIDTH+2:0] sum_o;
  logic                   match_o;
  logic                   err_sticky_o;
  logic [ERR_CNT_W-1:0]   err_cnt_o;

  // Drives codes into the checker, observes status
  modport master (
    output valid_i, x_in_i,
    output x_leaf1_i, x_leaf2_i, x_leaf3_i, x_leaf4_i,
    output x_leaf5_i, x_leaf6_i, x_leaf7_i, x_leaf8_i,
    output clear_i,
    input  valid_o, sum_o, match_o, err_sticky_o, err_cnt_o
  );

  // The recombiner check block itself
  modport slave (
    input  valid_i, x_in_i,
    input  x_leaf1_i, x_leaf2_i, x_leaf3_i, x_leaf4_i,
    input  x_leaf5_i, x_leaf6_i, x_leaf7_i, x_leaf8_i,
    input  clear_i,
    output valid_o, sum_o, match_o, err_sticky_o, err_cnt_o
  );

endinterface

// File: rtl/dem_tree_recombiner.sv
// Conservation checker for the three-layer DEM switching tree.
// The eight leaf codes are summed through a three-stage registered adder
// tree and compared with the tree input code, which is delayed to meet the
// leaves and then carried alongside the adder stages. Every stage carries
// its own valid bit; bubbles pass through unchanged and nothing stalls.
// Mismatches set a sticky flag and bump a saturating counter.
module dem_tree_recombiner #(
  parameter int unsigned INPUT_WIDTH = 4,
  parameter int unsigned TREE_LAT    = 3,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,   // asynchronous, active low
  dem_tree_recombiner_if.slave bus
);

  localparam int unsigned W = INPUT_WIDTH;

  // Leaves gathered into an array so the pair sums can be written uniformly
  logic [W-1:0] leaf [8];

  assign leaf[0] = bus.x_leaf1_i;
  assign leaf[1] = bus.x_leaf2_i;
  assign leaf[2] = bus.x_leaf3_i;
  assign leaf[3] = bus.x_leaf4_i;
  assign leaf[4] = bus.x_leaf5_i;
  assign leaf[5] = bus.x_leaf6_i;
  assign leaf[6] = bus.x_leaf7_i;
  assign leaf[7] = bus.x_leaf8_i;

  // Reference delay line
  logic         dl_valid [TREE_LAT];
  logic [W-1:0] dl_code  [TREE_LAT];
  logic         dvalid;
  logic [W-1:0] dcode;

  assign dvalid = dl_valid[TREE_LAT-1];
  assign dcode  = dl_code[TREE_LAT-1];

  // Adder stages, each with its reference copy and valid bit
  logic         s1_valid;
  logic [W:0]   s1_sum [4];
  logic [W-1:0] s1_ref;

  logic         s2_valid;
  logic [W+1:0] s2_sum [2];
  logic [W-1:0] s2_ref;

  logic         s3_valid;
  logic [W+2:0] s3_sum;
  logic [W-1:0] s3_ref;

  // Output register
  logic         valid_q;
  logic [W+2:0] sum_q;
  logic         match_q;

  // Error bookkeeping
  logic                 sticky_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic                 mismatch;

  // Combinational helpers
  logic [W:0]   pair_sum [4];
  logic [W+1:0] quad_sum [2];
  logic [W+2:0] oct_sum;
  logic         ref_eq;

  // Adder tree arithmetic; each level widens by one bit so nothing overflows
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      pair_sum[k] = {1'b0, leaf[2*k]} + {1'b0, leaf[2*k+1]};
    end
    quad_sum[0] = {1'b0, s1_sum[0]} + {1'b0, s1_sum[1]};
    quad_sum[1] = {1'b0, s1_sum[2]} + {1'b0, s1_sum[3]};
    oct_sum     = {1'b0, s2_sum[0]} + {1'b0, s2_sum[1]};
    ref_eq      = (s3_sum == {3'b000, s3_ref});
  end

  // Delay {valid, code} by TREE_LAT cycles to line up with the leaf outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < TREE_LAT; i++) begin
        dl_valid[i] <= 1'b0;
        dl_code[i]  <= '0;
      end
    end else begin
      dl_valid[0] <= bus.valid_i;
      dl_code[0]  <= bus.x_in_i;
      for (int unsigned i = 1; i < TREE_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_code[i]  <= dl_code[i-1];
      end
    end
  end

  // Stage 1: pair sums, leaves captured only when the delayed valid is set
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid <= 1'b0;
      s1_ref   <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        s1_sum[k] <= '0;
      end
    end else begin
      s1_valid <= dvalid;
      if (dvalid) begin
        s1_ref <= dcode;
        for (int unsigned k = 0; k < 4; k++) begin
          s1_sum[k] <= pair_sum[k];
        end
      end
    end
  end

  // Stage 2: two quad sums
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s2_valid  <= 1'b0;
      s2_ref    <= '0;
      s2_sum[0] <= '0;
      s2_sum[1] <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ref    <= s1_ref;
        s2_sum[0] <= quad_sum[0];
        s2_sum[1] <= quad_sum[1];
      end
    end
  end

  // Stage 3: final eight-leaf sum
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s3_valid <= 1'b0;
      s3_ref   <= '0;
      s3_sum   <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_ref <= s2_ref;
        s3_sum <= oct_sum;
      end
    end
  end

  // Output register: sum holds while invalid, match is forced low then
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      match_q <= 1'b0;
    end else begin
      valid_q <= s3_valid;
      match_q <= s3_valid && ref_eq;
      if (s3_valid) begin
        sum_q <= s3_sum;
      end
    end
  end

  assign mismatch = valid_q && !match_q;

  // Sticky flag and saturating counter; a reported mismatch beats clear
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (mismatch) begin
      sticky_q <= 1'b1;
      if (bus.clear_i) begin
        cnt_q <= ERR_CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
    end else if (bus.clear_i) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.sum_o        = sum_q;
  assign bus.match_o      = match_q;
  assign bus.err_sticky_o = sticky_q;
  assign bus.err_cnt_o    = cnt_q;

endmodule
